led_anim_seq: RTL and testbench

- Parametrised LED animation sequencer for the 7-segment pattern display path.
- Steps a frame index through a pattern table at a programmable rate and drives active-low segment outputs.
- Supports play-once, loop, ping-pong and reverse-loop modes, with pause/resume and a completion pulse.
- Replaces free-running external counters that feed a fixed combinational pattern decoder.

---
 rtl/led_anim_pkg.sv | 35 +++
 rtl/led_anim_if.sv | 28 ++
 rtl/led_pattern_rom.sv | 26 ++
 rtl/led_anim_seq.sv | 198 +++++++++++++++++++
 tb/tb_led_anim_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation sequencer: play modes, FSM
// states, the blank segment code and the default 7-segment pattern table.
package led_anim_pkg;

  localparam logic [1:0] MODE_ONCE     = 2'd0;
  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_REVERSE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } anim_state_t;

  // Active-low segments: all ones means every LED is dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int TABLE_DEPTH = 128;

  // Default 128-entry pattern table; only a handful of frames light anything.
  function automatic logic [6:0] pattern_lookup(input logic [31:0] idx);
    case (idx)
      32'd6:   return 7'b1110111;
      32'd53:  return 7'b1101111;
      32'd70:  return 7'b0111111;
      32'd98:  return 7'b0110110;
      32'd115: return 7'b1001111;
      32'd116: return 7'b1001001;
      32'd117: return 7'b1001111;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/led_anim_if.sv
// Control/status bundle between an animation controller and the sequencer.
interface led_anim_if #(
  parameter int SEG_W   = 7,
  parameter int FRAME_W = 7,
  parameter int RATE_W  = 16
);

  logic               start;
  logic               stop;
  logic               pause;
  logic [1:0]         mode;
  logic [RATE_W-1:0]  rate;
  logic [FRAME_W-1:0] frame_idx;
  logic [SEG_W-1:0]   seg_n;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, pause, mode, rate,
    input  frame_idx, seg_n, busy, done
  );

  modport slave (
    input  start, stop, pause, mode, rate,
    output frame_idx, seg_n, busy, done
  );

endinterface

// File: rtl/led_pattern_rom.sv
// Combinational lookup of the package pattern table. Indices beyond the
// configured frame count read as blank so a narrow table never lights junk.
module led_pattern_rom
  import led_anim_pkg::*;
#(
  parameter int SEG_W      = 7,
  parameter int FRAME_W    = 7,
  parameter int NUM_FRAMES = 128
) (
  input  logic [FRAME_W-1:0] idx,
  output logic [SEG_W-1:0]   seg
);

  localparam logic [31:0] FRAME_COUNT = 32'(NUM_FRAMES);

  // Table read, blank outside the populated range.
  always_comb begin
    seg = {SEG_W{1'b1}};
    if (32'(idx) < FRAME_COUNT) begin
      seg = SEG_W'(pattern_lookup(32'(idx)));
    end else begin
      seg = {SEG_W{1'b1}};
    end
  end

endmodule

// File: rtl/led_anim_seq.sv
// LED animation sequencer: walks a frame index through the pattern table at
// a programmable dwell rate in once/loop/ping-pong/reverse modes, with
// pause/resume, abort, and a completion pulse for play-once.
module led_anim_seq
  import led_anim_pkg::*;
#(
  parameter int SEG_W      = 7,
  parameter int FRAME_W    = 7,
  parameter int NUM_FRAMES = 128,
  parameter int RATE_W     = 16
) (
  input logic       clk,
  input logic       rst_n,
  led_anim_if.slave bus
);

  localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [RATE_W-1:0]  RATE_ZERO  = {RATE_W{1'b0}};
  localparam logic [RATE_W-1:0]  RATE_ONE   = RATE_W'(1);
  localparam logic [SEG_W-1:0]   SEG_OFF    = {SEG_W{1'b1}};

  anim_state_t        state;
  anim_state_t        state_next;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_next;
  logic [RATE_W-1:0]  div_cnt;
  logic [RATE_W-1:0]  div_next;
  logic [RATE_W-1:0]  div_last;
  logic [RATE_W-1:0]  rate_q;
  logic [RATE_W-1:0]  rate_next;
  logic [1:0]         mode_q;
  logic [1:0]         mode_next;
  logic               dir_up;
  logic               dir_next;
  logic [SEG_W-1:0]   seg;
  logic [SEG_W-1:0]   seg_next;
  logic [SEG_W-1:0]   rom_seg;
  logic               busy;
  logic               done;
  logic               done_next;
  logic               tick;

  led_pattern_rom #(
    .SEG_W      (SEG_W),
    .FRAME_W    (FRAME_W),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_rom (
    .idx (frame),
    .seg (rom_seg)
  );

  // Last divider count of a frame; a programmed rate of 0 dwells one cycle.
  always_comb begin
    if (rate_q == RATE_ZERO) begin
      div_last = RATE_ZERO;
    end else begin
      div_last = rate_q - RATE_ONE;
    end
  end

  assign tick = (div_cnt == div_last);

  // Next state, frame and divider; stop beats start beats pause beats tick.
  always_comb begin
    state_next = state;
    frame_next = frame;
    div_next   = div_cnt;
    dir_next   = dir_up;
    mode_next  = mode_q;
    rate_next  = rate_q;
    done_next  = 1'b0;
    if (bus.stop) begin
      state_next = ST_IDLE;
      frame_next = FRAME_ZERO;
      div_next   = RATE_ZERO;
      dir_next   = 1'b1;
    end else if (bus.start) begin
      state_next = ST_RUN;
      mode_next  = bus.mode;
      rate_next  = bus.rate;
      div_next   = RATE_ZERO;
      dir_next   = 1'b1;
      if (bus.mode == MODE_REVERSE) begin
        frame_next = FRAME_LAST;
      end else begin
        frame_next = FRAME_ZERO;
      end
    end else if (state == ST_IDLE) begin
      state_next = ST_IDLE;
    end else if (bus.pause) begin
      // Divider and frame freeze; leaving pause resumes counting at once.
      state_next = ST_PAUSE;
    end else begin
      state_next = ST_RUN;
      if (tick) begin
        div_next = RATE_ZERO;
        case (mode_q)
          MODE_ONCE: begin
            if (frame == FRAME_LAST) begin
              state_next = ST_IDLE;
              frame_next = FRAME_ZERO;
              done_next  = 1'b1;
            end else begin
              frame_next = frame + FRAME_ONE;
            end
          end
          MODE_LOOP: begin
            if (frame == FRAME_LAST) begin
              frame_next = FRAME_ZERO;
            end else begin
              frame_next = frame + FRAME_ONE;
            end
          end
          MODE_PINGPONG: begin
            // Turn around at each end so endpoints are shown only once.
            if (dir_up) begin
              if (frame == FRAME_LAST) begin
                dir_next   = 1'b0;
                frame_next = frame - FRAME_ONE;
              end else begin
                frame_next = frame + FRAME_ONE;
              end
            end else begin
              if (frame == FRAME_ZERO) begin
                dir_next   = 1'b1;
                frame_next = frame + FRAME_ONE;
              end else begin
                frame_next = frame - FRAME_ONE;
              end
            end
          end
          MODE_REVERSE: begin
            if (frame == FRAME_ZERO) begin
              frame_next = FRAME_LAST;
            end else begin
              frame_next = frame - FRAME_ONE;
            end
          end
          default: begin
            frame_next = frame;
          end
        endcase
      end else begin
        div_next = div_cnt + RATE_ONE;
      end
    end
  end

  // Segment register follows the current frame, blanked whenever going idle.
  always_comb begin
    seg_next = SEG_OFF;
    if (state_next != ST_IDLE) begin
      seg_next = rom_seg;
    end else begin
      seg_next = SEG_OFF;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= FRAME_ZERO;
      div_cnt <= RATE_ZERO;
      dir_up  <= 1'b1;
      mode_q  <= MODE_ONCE;
      rate_q  <= RATE_ZERO;
      seg     <= SEG_OFF;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      frame   <= frame_next;
      div_cnt <= div_next;
      dir_up  <= dir_next;
      mode_q  <= mode_next;
      rate_q  <= rate_next;
      seg     <= seg_next;
      busy    <= (state_next != ST_IDLE);
      done    <= done_next;
    end
  end

  assign bus.frame_idx = frame;
  assign bus.seg_n     = seg;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_led_anim_seq.sv
// Bench for led_anim_seq: a 128-frame and an 8-frame instance share stimulus;
// a tick-count model predicts every output each cycle, and directed checks
// pin literal values from the pattern table and sequencing rules.
module tb_led_anim_seq;
  import led_anim_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] rate = 16'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_anim_if #(.SEG_W(7), .FRAME_W(7), .RATE_W(16)) bus0 ();
  led_anim_if #(.SEG_W(7), .FRAME_W(7), .RATE_W(16)) bus1 ();

  assign bus0.start = start;
  assign bus0.stop  = stop;
  assign bus0.pause = pause;
  assign bus0.mode  = mode;
  assign bus0.rate  = rate;
  assign bus1.start = start;
  assign bus1.stop  = stop;
  assign bus1.pause = pause;
  assign bus1.mode  = mode;
  assign bus1.rate  = rate;

  led_anim_seq #(.SEG_W(7), .FRAME_W(7), .NUM_FRAMES(128), .RATE_W(16)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0));
  led_anim_seq #(.SEG_W(7), .FRAME_W(7), .NUM_FRAMES(8), .RATE_W(16)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1));

  logic [6:0] a_frame [2];
  logic [6:0] a_seg   [2];
  logic       a_busy  [2];
  logic       a_done  [2];
  assign a_frame[0] = bus0.frame_idx;
  assign a_seg[0]   = bus0.seg_n;
  assign a_busy[0]  = bus0.busy;
  assign a_done[0]  = bus0.done;
  assign a_frame[1] = bus1.frame_idx;
  assign a_seg[1]   = bus1.seg_n;
  assign a_busy[1]  = bus1.busy;
  assign a_done[1]  = bus1.done;

  // Model state: frame is derived from the number of ticks since start.
  int nf [2] = '{128, 8};
  int m_busy [2];
  int m_frame [2];
  int m_prev [2];
  int m_done [2];
  int m_div [2];
  int m_k [2];
  int m_mode = 0;
  int m_rate = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_pat(input int i);
    case (i)
      6:       return 7'b1110111;
      53:      return 7'b1101111;
      70:      return 7'b0111111;
      98:      return 7'b0110110;
      115:     return 7'b1001111;
      116:     return 7'b1001001;
      117:     return 7'b1001111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Frame shown after k ticks in a given mode for an n-frame table.
  function automatic int frame_of(input int md, input int k, input int n);
    int p;
    p = 0;
    case (md)
      0, 1: return k % n;
      2: begin
        p = k % (2 * n - 2);
        return (p < n) ? p : (2 * n - 2 - p);
      end
      default: return n - 1 - (k % n);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_frame[i] = 0; m_prev[i] = 0;
      m_done[i] = 0; m_div[i] = 0; m_k[i] = 0;
    end
    m_mode = 0;
    m_rate = 1;
  endtask

  // Advance the model by one clock using the inputs the next edge samples.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = m_frame[i];
      m_done[i] = 0;
      if (stop) begin
        m_busy[i] = 0; m_frame[i] = 0;
      end else if (start) begin
        m_busy[i] = 1; m_k[i] = 0; m_div[i] = 0;
        m_frame[i] = frame_of(int'(mode), 0, nf[i]);
      end else if (m_busy[i] != 0 && !pause) begin
        if (m_div[i] == m_rate - 1) begin
          m_div[i] = 0;
          m_k[i]++;
          if (m_mode == 0 && m_k[i] == nf[i]) begin
            m_busy[i] = 0; m_done[i] = 1; m_frame[i] = 0;
          end else begin
            m_frame[i] = frame_of(m_mode, m_k[i], nf[i]);
          end
        end else begin
          m_div[i]++;
        end
      end
    end
    if (!stop && start) begin
      m_mode = int'(mode);
      m_rate = (rate == 16'd0) ? 1 : int'(rate);
    end
  endtask

  // Per-cycle comparison against the model on the falling edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("n%0d_frame", nf[i]), 32'(a_frame[i]), 32'(m_frame[i]));
        check($sformatf("n%0d_busy", nf[i]), 32'(a_busy[i]), 32'(m_busy[i]));
        check($sformatf("n%0d_done", nf[i]), 32'(a_done[i]), 32'(m_done[i]));
        check($sformatf("n%0d_seg", nf[i]), 32'(a_seg[i]),
              32'((m_busy[i] != 0) ? exp_pat(m_prev[i]) : 7'b1111111));
      end
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One-cycle start; afterwards mode/rate are scrambled to prove they are latched.
  task automatic kick(input logic [1:0] md, input logic [15:0] rt);
    start = 1'b1; mode = md; rate = rt;
    tick_n(1);
    start = 1'b0; mode = ~md; rate = rt + 16'd7;
  endtask

  task automatic wait_frame0(input int target, input int limit, output int cnt);
    cnt = 0;
    while (a_frame[0] != 7'(target) && cnt < limit) begin
      tick_n(1);
      cnt++;
    end
    check($sformatf("wait_frame_%0d", target), 32'(a_frame[0] == 7'(target)), 32'd1);
  endtask

  int pp_exp [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int rv_exp [9]  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin : stimulus
    int cnt;
    cnt = 0;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(10);
    check("idle_seg", 32'(a_seg[0]), 32'h7f);
    check("idle_busy", 32'(a_busy[0]), 32'd0);
    check("idle_frame", 32'(a_frame[0]), 32'd0);

    // Loop at two cycles per frame.
    kick(2'd1, 16'd2);
    check("loop_first", 32'(a_frame[0]), 32'd0);
    wait_frame0(6, 40, cnt);
    check("loop_seg_lag_before", 32'(a_seg[0]), 32'h7f);
    tick_n(1);
    check("loop_seg_6", 32'(a_seg[0]), 32'b1110111);
    check("loop_frame_hold", 32'(a_frame[0]), 32'd6);
    wait_frame0(127, 400, cnt);
    tick_n(2);
    check("loop_wrap", 32'(a_frame[0]), 32'd0);
    check("loop_busy", 32'(a_busy[0]), 32'd1);

    // Play once at full rate (restarted from a running loop).
    kick(2'd0, 16'd1);
    wait_frame0(115, 300, cnt);
    check("once_count_115", 32'(cnt), 32'd115);
    tick_n(1);
    check("seg_115", 32'(a_seg[0]), 32'b1001111);
    tick_n(1);
    check("seg_116", 32'(a_seg[0]), 32'b1001001);
    tick_n(1);
    check("seg_117", 32'(a_seg[0]), 32'b1001111);
    wait_frame0(127, 20, cnt);
    check("once_done_early", 32'(a_done[0]), 32'd0);
    tick_n(1);
    check("once_done", 32'(a_done[0]), 32'd1);
    check("once_busy_off", 32'(a_busy[0]), 32'd0);
    check("once_frame0", 32'(a_frame[0]), 32'd0);
    check("once_blank", 32'(a_seg[0]), 32'h7f);
    tick_n(1);
    check("once_done_pulse", 32'(a_done[0]), 32'd0);

    // Ping-pong on the 8-frame instance.
    kick(2'd2, 16'd1);
    for (int j = 0; j < 17; j++) begin
      check($sformatf("pingpong_%0d", j), 32'(a_frame[1]), 32'(pp_exp[j]));
      tick_n(1);
    end

    // Reverse started mid-run.
    kick(2'd3, 16'd1);
    check("rev_start_127", 32'(a_frame[0]), 32'd127);
    for (int j = 0; j < 9; j++) begin
      check($sformatf("reverse_%0d", j), 32'(a_frame[1]), 32'(rv_exp[j]));
      tick_n(1);
    end

    // Pause in the middle of a frame's dwell.
    kick(2'd1, 16'd4);
    wait_frame0(6, 60, cnt);
    tick_n(2);
    pause = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick_n(1);
      check("pause_frame", 32'(a_frame[0]), 32'd6);
      check("pause_seg", 32'(a_seg[0]), 32'b1110111);
    end
    pause = 1'b0;
    tick_n(1);
    check("resume_hold", 32'(a_frame[0]), 32'd6);
    tick_n(1);
    check("resume_tick", 32'(a_frame[0]), 32'd7);

    // Rate 0 dwells one cycle.
    kick(2'd1, 16'd0);
    check("rate0_f0", 32'(a_frame[0]), 32'd0);
    tick_n(1);
    check("rate0_f1", 32'(a_frame[0]), 32'd1);
    tick_n(1);
    check("rate0_f2", 32'(a_frame[0]), 32'd2);

    // Start and stop together.
    start = 1'b1; stop = 1'b1; mode = 2'd1; rate = 16'd1;
    tick_n(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(a_busy[0]), 32'd0);
    check("startstop_frame", 32'(a_frame[0]), 32'd0);
    check("startstop_seg", 32'(a_seg[0]), 32'h7f);

    // Plain stop from a running ping-pong.
    kick(2'd2, 16'd3);
    tick_n(7);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    check("stop_busy", 32'(a_busy[1]), 32'd0);
    tick_n(2);

    // Asynchronous reset mid-run.
    kick(2'd1, 16'd1);
    tick_n(20);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(a_busy[0]), 32'd0);
    check("rst_frame", 32'(a_frame[0]), 32'd0);
    check("rst_seg", 32'(a_seg[0]), 32'h7f);
    check("rst_done", 32'(a_done[0]), 32'd0);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
